// File: rtl/seq_mult8_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult8_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   state_t     - FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   OP_W        - operand width (8)
//   ITERATIONS  - shift-and-add iterations per multiply (8)
//   PROD_W      - product width (16)
//   cnt_t       - iteration counter type, LAST_CNT its terminal value
// No ports (package).
// -----------------------------------------------------------------------------
package seq_mult8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int OP_W       = 8;
  localparam int ITERATIONS = 8;
  localparam int PROD_W     = 2 * OP_W;
  localparam int CNT_W      = $clog2(ITERATIONS);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LAST_CNT = cnt_t'(ITERATIONS - 1);

endpackage : seq_mult8_pkg

// File: rtl/seq_mult8_step.sv
// -----------------------------------------------------------------------------
// mult8_step
// Purely combinational single iteration of the shift-and-add multiplier.
// Ports:
//   acc         in  16 : running partial product
//   mcand       in  16 : multiplicand, already shifted left by the step index
//   mplier      in  8  : remaining multiplier bits, LSB is the current bit
//   acc_next    out 16 : acc + mcand when mplier[0] is set, else acc
//   mcand_next  out 16 : mcand << 1 (zero fill)
//   mplier_next out 8  : mplier >> 1 (zero fill)
//   mplier_zero out 1  : mplier_next has no set bits left
// -----------------------------------------------------------------------------
module mult8_step
  import seq_mult8_pkg::*;
(
  input  logic [PROD_W-1:0] acc,
  input  logic [PROD_W-1:0] mcand,
  input  logic [OP_W-1:0]   mplier,
  output logic [PROD_W-1:0] acc_next,
  output logic [PROD_W-1:0] mcand_next,
  output logic [OP_W-1:0]   mplier_next,
  output logic              mplier_zero
);

  // The 16-bit sum cannot overflow: the largest final value is 255*255.
  assign acc_next    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_next  = mcand << 1;
  assign mplier_next = mplier >> 1;
  assign mplier_zero = (mplier_next == '0);

endmodule : mult8_step

// File: rtl/seq_mult8.sv
// -----------------------------------------------------------------------------
// seq_mult8
// Sequential unsigned multiplier, one shift-and-add iteration per clock, with
// a start/busy/done handshake and a registered product.
// Ports:
//   clk     in  1        : clock, rising edge
//   rst     in  1        : synchronous active-high reset
//   start   in  1        : request a multiply, honoured only while not busy
//   a       in  WIDTH    : multiplicand, captured on the accepting edge
//   b       in  WIDTH    : multiplier, captured on the accepting edge
//   busy    out 1        : iterations in progress (state RUN)
//   done    out 1        : one-cycle pulse, product just became valid
//   product out 2*WIDTH  : result, held until next completion or reset
// Build option:
//   SEQ_MULT8_EARLY_TERM_EN - finish as soon as no multiplier bits remain.
// Only WIDTH = 8 is supported.
// -----------------------------------------------------------------------------
module seq_mult8
  import seq_mult8_pkg::*;
#(
  parameter int WIDTH = OP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_t state, state_next;

  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0]   mplier;
  cnt_t               cnt;

  logic [2*WIDTH-1:0] acc_next, mcand_next;
  logic [WIDTH-1:0]   mplier_next;
  logic               last_iter;

  // ---------------------------------------------------------------------------
  // One-iteration datapath
  // ---------------------------------------------------------------------------
`ifdef SEQ_MULT8_EARLY_TERM_EN
  logic mplier_zero;

  mult8_step u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (acc_next),
    .mcand_next  (mcand_next),
    .mplier_next (mplier_next),
    .mplier_zero (mplier_zero)
  );

  // Once the shifted multiplier is empty, later iterations would add nothing.
  assign last_iter = (cnt == LAST_CNT) || mplier_zero;
`else
  mult8_step u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (acc_next),
    .mcand_next  (mcand_next),
    .mplier_next (mplier_next),
    .mplier_zero ()
  );

  assign last_iter = (cnt == LAST_CNT);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from the registered state, so glitch-free)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand_next;
          mplier <= mplier_next;
          cnt    <= cnt + cnt_t'(1);
          // Product is loaded only here, so it never moves mid-operation.
          if (last_iter) product <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule : seq_mult8
